// File: rtl/pmic_pkg.sv
// Shared types and constants for the PMIC power sequencer.
package pmic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UP_WAIT,
    ON,
    DN_WAIT,
    FAULT
  } state_t;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_PG0     = 3'd1;
  localparam logic [2:0] FC_PG1     = 3'd2;
  localparam logic [2:0] FC_PG2     = 3'd3;
  localparam logic [2:0] FC_PG3     = 3'd4;
  localparam logic [2:0] FC_PG_LOST = 3'd5;
  localparam logic [2:0] FC_WDOG    = 3'd6;

  localparam logic [4:0] SEL_PRE = 5'b00001;
  localparam logic [4:0] SEL_DN  = 5'b10000;

  // Enabled rails always form a contiguous low-order set, so dropping the
  // highest enabled rail is a plain right shift.
  function automatic logic [3:0] drop_top(input logic [3:0] rails);
    return rails >> 1;
  endfunction

endpackage

// File: rtl/pmic_pg_sync.sv
// Multi-flop synchroniser for the four asynchronous power-good inputs.
module pmic_pg_sync
  import pmic_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

  logic [3:0] ff [N];

  // Shift the raw pg bits through N flops; the last stage is the usable value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) ff[i] <= '0;
    end else begin
      ff[0] <= d;
      for (int unsigned i = 1; i < N; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/pmic_power_sequencer.sv
// PMIC power sequencer: brings up four rails in order through the shared
// timer, checks each rail's power-good, holds ON, powers down in reverse and
// latches a fault cause on any pg failure.
// Optional build macro PMIC_SEQ_WATCHDOG_EN adds a timer-done watchdog.
module pmic_power_sequencer
  import pmic_pkg::*;
#(
  parameter int unsigned PG_SYNC     = 2,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear_fault,
  input  logic [3:0] pg,
  output logic       timer_ld,
  output logic [4:0] timer_sel,
  input  logic [4:0] timer_T,
  output logic [3:0] rail_en,
  output logic       pwr_ok,
  output logic       busy,
  output logic       fault,
  output logic [2:0] fault_code
);

  state_t     state;
  logic [2:0] step;
  logic       abort;
  logic [3:0] pg_s;
  logic       done;
  logic       wd_expire;
  logic [1:0] chk_idx;

  pmic_pg_sync #(.STAGES(PG_SYNC)) u_pg_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pg),
    .q     (pg_s)
  );

  assign done    = |(timer_T & timer_sel);
  assign chk_idx = 2'(step - 3'd1);

  assign pwr_ok = (state == ON);
  assign busy   = (state == UP_WAIT) || (state == DN_WAIT);
  assign fault  = (state == FAULT);

`ifdef PMIC_SEQ_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);

  logic [WDW-1:0] wd_cnt;

  // Count cycles elapsed since the load edge; the load strobe itself marks
  // the first elapsed cycle, so expiry lands exactly WDOG_CYCLES after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (timer_ld) begin
      wd_cnt <= WDW'(1);
    end else if (busy && (wd_cnt != WDW'(WDOG_CYCLES))) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expire = busy && !timer_ld && (wd_cnt == WDW'(WDOG_CYCLES - 1));
`else
  assign wd_expire = 1'b0;
`endif

  // Sequencing FSM with registered timer strobe, select, rail enables and code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      step       <= '0;
      abort      <= 1'b0;
      timer_ld   <= 1'b0;
      timer_sel  <= '0;
      rail_en    <= '0;
      fault_code <= FC_NONE;
    end else begin
      timer_ld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            timer_ld  <= 1'b1;
            timer_sel <= SEL_PRE;
            step      <= '0;
            abort     <= 1'b0;
            state     <= UP_WAIT;
          end
        end

        UP_WAIT: begin
          if (done) begin
            // An abort consumes the outstanding done first so the timer is
            // idle before the power-down walk starts.
            if (abort || stop) begin
              abort <= 1'b0;
              if (rail_en == '0) begin
                timer_sel <= '0;
                state     <= IDLE;
              end else begin
                rail_en   <= drop_top(rail_en);
                timer_ld  <= 1'b1;
                timer_sel <= SEL_DN;
                state     <= DN_WAIT;
              end
            end else if ((step != '0) && !pg_s[chk_idx]) begin
              rail_en    <= '0;
              timer_sel  <= '0;
              fault_code <= FC_PG0 + 3'(chk_idx);
              state      <= FAULT;
            end else if (step == 3'd4) begin
              timer_sel <= '0;
              state     <= ON;
            end else begin
              rail_en   <= {rail_en[2:0], 1'b1};
              timer_ld  <= 1'b1;
              timer_sel <= timer_sel << 1;
              step      <= step + 3'd1;
            end
          end else if (wd_expire) begin
            rail_en    <= '0;
            timer_sel  <= '0;
            abort      <= 1'b0;
            fault_code <= FC_WDOG;
            state      <= FAULT;
          end else if (stop) begin
            abort <= 1'b1;
          end
        end

        ON: begin
          if (pg_s != 4'hF) begin
            rail_en    <= '0;
            fault_code <= FC_PG_LOST;
            state      <= FAULT;
          end else if (stop) begin
            rail_en   <= drop_top(rail_en);
            timer_ld  <= 1'b1;
            timer_sel <= SEL_DN;
            state     <= DN_WAIT;
          end
        end

        DN_WAIT: begin
          if (done) begin
            if (rail_en == '0) begin
              timer_sel <= '0;
              state     <= IDLE;
            end else begin
              rail_en   <= drop_top(rail_en);
              timer_ld  <= 1'b1;
              timer_sel <= SEL_DN;
            end
          end else if (wd_expire) begin
            rail_en    <= '0;
            timer_sel  <= '0;
            fault_code <= FC_WDOG;
            state      <= FAULT;
          end
        end

        FAULT: begin
          if (clear_fault) begin
            fault_code <= FC_NONE;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmic_power_sequencer.sv
// Directed bench for pmic_power_sequencer with a behavioural timer and
// pg looped back from rail_en through a two-cycle delay.
module tb_pmic_power_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, clear_fault;
  logic [3:0] pg;
  logic       timer_ld;
  logic [4:0] timer_sel;
  logic [4:0] timer_T;
  logic [3:0] rail_en;
  logic       pwr_ok, busy, fault;
  logic [2:0] fault_code;

  int total = 0;
  int bad   = 0;

  int         lim [5];
  logic       mute;
  logic [3:0] pg_mask;
  logic [3:0] d1, d2;

  logic [4:0] ldq [$];
  logic [3:0] rq  [$];
  logic [3:0] prev_rail = '0;

  pmic_power_sequencer #(.PG_SYNC(2), .WDOG_CYCLES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .clear_fault (clear_fault),
    .pg          (pg),
    .timer_ld    (timer_ld),
    .timer_sel   (timer_sel),
    .timer_T     (timer_T),
    .rail_en     (rail_en),
    .pwr_ok      (pwr_ok),
    .busy        (busy),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  function automatic int lim_of(input logic [4:0] s);
    for (int i = 0; i < 5; i++) if (s[i]) return lim[i];
    return 0;
  endfunction

  // Timer model: done pulse equal to the loaded select, lim cycles after load.
  logic       t_run;
  int         t_cnt;
  logic [4:0] t_sel;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t_run <= 1'b0; t_cnt <= 0; t_sel <= '0; timer_T <= '0;
    end else begin
      timer_T <= '0;
      if (timer_ld) begin
        t_run <= 1'b1; t_cnt <= 0; t_sel <= timer_sel;
      end else if (t_run) begin
        if (t_cnt == lim_of(t_sel)) begin
          t_run <= 1'b0;
          if (!mute) timer_T <= t_sel;
        end else begin
          t_cnt <= t_cnt + 1;
        end
      end
    end
  end

  // pg follows rail_en two cycles late, with per-bit forced failures.
  always @(posedge clk or posedge reset) begin
    if (reset) begin d1 <= '0; d2 <= '0; end
    else begin d1 <= rail_en; d2 <= d1; end
  end
  assign pg = d2 & ~pg_mask;

  // Record load selects and rail_en changes.
  always @(negedge clk) begin
    if (timer_ld) ldq.push_back(timer_sel);
    if (rail_en !== prev_rail) begin
      rq.push_back(rail_en);
      prev_rail = rail_en;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_r();
    logic [63:0] w = '0;
    foreach (rq[i]) w = (w << 4) | 64'(rq[i]);
    return w;
  endfunction

  function automatic logic [63:0] pack_ld();
    logic [63:0] w = '0;
    foreach (ldq[i]) w = (w << 8) | 64'(ldq[i]);
    return w;
  endfunction

  // what: 0 = ON, 1 = FAULT, 2 = IDLE
  task automatic wait_for(input string tag, input int what, input int budget);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (what)
        0:       hit = pwr_ok;
        1:       hit = fault;
        default: hit = !busy && !pwr_ok && !fault;
      endcase
    end
    #1;
    if (!hit) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    @(negedge clk); #1;
    clear_fault = 1'b0;
  endtask

  task automatic clr_q();
    ldq.delete();
    rq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    lim[0] = 5; lim[1] = 6; lim[2] = 5; lim[3] = 3; lim[4] = 3;
    mute = 1'b0; pg_mask = '0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear_fault = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", {timer_ld, timer_sel, rail_en, pwr_ok, busy, fault, fault_code}, 64'd0);
    reset = 1'b0;
    @(negedge clk); #1;

    // full power-up
    clr_q();
    pulse_start();
    wait_for("up", 0, 200);
    check("up_pwr_ok", pwr_ok, 1);
    check("up_rail", rail_en, 4'hF);
    check("up_walk", pack_r(), 64'h137F);
    check("up_ld_n", ldq.size(), 5);
    check("up_sels", pack_ld(), 64'h0102040810);

    // power-down from ON
    clr_q();
    stop = 1'b1;
    wait_for("dn", 2, 200);
    stop = 1'b0;
    check("dn_walk", pack_r(), 64'h7310);
    check("dn_sels", pack_ld(), 64'h10101010);
    check("dn_rail", rail_en, 0);

    // pg[2] stuck low during power-up
    pg_mask = 4'b0100;
    clr_q();
    pulse_start();
    wait_for("pg2", 1, 200);
    check("pg2_rail_at_fault", rail_en, 0);
    check("pg2_code", fault_code, 3);
    check("pg2_walk", pack_r(), 64'h1370);
    check("pg2_sels", pack_ld(), 64'h01020408);
    pulse_clear();
    check("pg2_clr_code", fault_code, 0);
    check("pg2_clr_fault", fault, 0);
    pg_mask = '0;

    // stop coinciding with pg[1] loss in ON: fault wins
    clr_q();
    pulse_start();
    wait_for("lost_up", 0, 200);
    clr_q();
    pg_mask = 4'b0010;
    @(negedge clk);
    @(negedge clk); #1;
    stop = 1'b1;
    wait_for("lost", 1, 50);
    check("lost_code", fault_code, 5);
    check("lost_walk_n", rq.size(), 1);
    check("lost_rail", rail_en, 0);
    stop = 1'b0;
    pg_mask = '0;
    pulse_clear();
    wait_for("lost_idle", 2, 10);
    check("lost_clr_code", fault_code, 0);

    // stop mid power-up once rails 0 and 1 are on
    clr_q();
    pulse_start();
    begin
      int n = 0;
      while (rail_en !== 4'b0011 && n < 100) begin @(negedge clk); n++; end
      check("abort_reach", rail_en, 4'b0011);
    end
    #1;
    stop = 1'b1;
    wait_for("abort", 2, 200);
    stop = 1'b0;
    check("abort_walk", pack_r(), 64'h1310);
    check("abort_sels", pack_ld(), 64'h0102041010);
    check("abort_code", fault_code, 0);

`ifdef PMIC_SEQ_WATCHDOG_EN
    // done never arrives: watchdog fault 10 cycles after the load
    mute = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("wd_ld_seen", timer_ld, 1);
    #1;
    start = 1'b0;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!fault && n < 30);
      check("wd_latency", n, 10);
    end
    check("wd_code", fault_code, 6);
    check("wd_rail", rail_en, 0);
    mute = 1'b0;
    #1;
    pulse_clear();
    wait_for("wd_idle", 2, 10);

    // done arrives on the expiry cycle: no fault
    lim[0] = 7;
    pulse_start();
    wait_for("wd_tie", 0, 200);
    check("wd_tie_code", fault_code, 0);
    check("wd_tie_fault", fault, 0);
    lim[0] = 5;
    stop = 1'b1;
    wait_for("wd_tie_dn", 2, 200);
    stop = 1'b0;
`endif

    // asynchronous reset while ON, then a clean repeat
    pulse_start();
    wait_for("rst_up", 0, 200);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", {timer_ld, timer_sel, rail_en, pwr_ok, busy, fault, fault_code}, 64'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_idle_busy", busy, 0);
    clr_q();
    pulse_start();
    wait_for("rst_again", 0, 200);
    check("rst_again_walk", pack_r(), 64'h137F);
    check("rst_again_sels", pack_ld(), 64'h0102040810);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmic_power_sequencer.md
Name: pmic_power_sequencer

Overview:
- Initiator side of the `timer` load/select/done interface: pulses `timer_ld` with a one-hot `timer_sel`, then waits for the matching `timer_T` done bit.
- Sequences four PMIC rail enables in order. After each rail's settle delay it checks that rail's power-good (pg) input, then holds the ON state.
- Powers down in reverse order. On any pg failure it latches a fault with a cause code.
- Sits between the top-level control inputs and the `timer` instance plus the rail-enable pins.

Parameters:
- PG_SYNC, 2, number of synchroniser flops on each pg input (minimum 2).
- WDOG_CYCLES, 64, maximum cycles allowed between `timer_ld` and the matching done bit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- start  in  1  power-up request; level, sampled in IDLE
- stop  in  1  power-down request; level
- clear_fault  in  1  leaves FAULT; sampled only in FAULT
- pg  in  4  rail power-good, asynchronous inputs
- timer_ld  out  1  one-cycle load strobe to the timer
- timer_sel  out  5  one-hot delay select to the timer
- timer_T  in  5  timer done vector; one-cycle pulse equal to the loaded select
- rail_en  out  4  rail enables; bit k drives rail k
- pwr_ok  out  1  high only in ON
- busy  out  1  high in UP_WAIT, DN_WAIT
- fault  out  1  high in FAULT
- fault_code  out  3  0 none; 1-4 pg fail on rail 0-3 during power-up; 5 pg lost in ON; 6 watchdog

Behaviour:
- Reset values: all outputs 0; state IDLE; step=0; synchronisers cleared.
- pg is synchronised through PG_SYNC flops. All pg checks use the synchronised value `pg_s`.
- Timer handshake:
  - `timer_ld` is high exactly one cycle per delay. `timer_sel` is driven in that same cycle and held until the expected done bit arrives.
  - Expected bit = `timer_sel`. Completion is `|(timer_T & timer_sel)`; any other `timer_T` bits are ignored.
  - `timer_ld` is never reissued while a delay is outstanding.
- Power-up delay selects: step 0 = 5'b00001 (pre-delay), step k+1 = 1<<(k+1) for rail k (k=0..3). Power-down delay select = 5'b10000.
- States:
  - IDLE: if stop, remain. Else if start: `timer_ld`=1, sel=00001, step=0, go UP_WAIT.
  - UP_WAIT, on done:
    - step=0: set `rail_en[0]`, load sel=00010, step=1.
    - step=k+1: if `pg_s[k]`=0, go FAULT with code k+1. Else if k<3, set `rail_en[k+1]` and load 1<<(k+2). Else (k=3) go ON.
  - ON: `pwr_ok`=1.
    - Any `pg_s` bit 0 -> FAULT, code 5. This has priority over stop in the same cycle.
    - Else if stop: clear the highest set `rail_en` bit, load sel=10000, go DN_WAIT.
  - DN_WAIT, on done: if `rail_en`==0 go IDLE. Else clear the next-highest set bit and reload 10000.
  - FAULT:
    - Entry clears all `rail_en` in the same edge that enters FAULT. `fault`=1; `fault_code` holds its value.
    - clear_fault -> IDLE, `fault_code`=0. start and stop are ignored.
- stop during UP_WAIT: abort.
  - Wait for the outstanding done bit so the timer is idle. During this wait no further rail is enabled and the pg check is skipped.
  - Then begin the power-down walk from the highest enabled rail. If no rail is enabled yet, go directly to IDLE.
- start and stop together in IDLE: stop wins and the block stays idle.
- Reset mid-sequence: all rails drop asynchronously. The timer is reset by the same signal.
- `rail_en` only ever changes to rail k+1 after rail k's pg check passes. The enabled rails are always a contiguous low-order set.

Optional Feature:
- Macro: PMIC_SEQ_WATCHDOG_EN.
- When defined:
  - A counter of width $clog2(WDOG_CYCLES+1) clears on every `timer_ld` and counts in UP_WAIT and DN_WAIT.
  - Reaching WDOG_CYCLES with no done bit -> FAULT, code 6, all rails off.
  - A done bit and a counter expiry in the same cycle: done wins.
- When undefined: no counter is present; the block waits indefinitely and code 6 is never produced.

Decomposition:
- Shared package pmic_pkg holds:
  - the state enum (IDLE, UP_WAIT, ON, DN_WAIT, FAULT);
  - the fault_code localparams (FC_NONE=0, FC_PG0..3=1-4, FC_PG_LOST=5, FC_WDOG=6);
  - the select constants (SEL_PRE=5'b00001, SEL_DN=5'b10000).
- One natural sub-module: pmic_pg_sync, the parameterised 4-bit multi-flop synchroniser.

Test Plan:
Bench instantiates the team's `timer` with limits 5/6/5/3/3; pg is tied to `rail_en` delayed 2 cycles.
- Pulse start with all pg good: `timer_sel` steps through 00001, 00010, 00100, 01000, 10000. `rail_en` walks 0001->0011->0111->1111. `pwr_ok`=1, `timer_ld` high exactly 5 single cycles.
- Hold pg[2]=0, start: `rail_en` reaches 0111, then FAULT with `fault_code`=3. `rail_en`=0 on the cycle FAULT is entered. clear_fault -> IDLE, code 0.
- In ON, raise stop: `rail_en` 1111->0111->0011->0001->0000 with sel=10000 each step, then IDLE. Assert stop together with pg[1] low in ON instead: FAULT with code 5.
- Stop while `rail_en`=0011 mid-up: no third rail enabled; the outstanding done bit is consumed, then reverse walk to 0000 and IDLE.
- With PMIC_SEQ_WATCHDOG_EN and `timer_T` forced to 0, WDOG_CYCLES=10: FAULT with code 6 exactly 10 cycles after `timer_ld`. Done and expiry in the same cycle: no fault.
- Assert reset in ON: all outputs 0 asynchronously. After release, state is IDLE and start repeats the full sequence.
